// File: rtl/rrfifo_replay_ctrl.sv
// Replay sequencer for one re-readable operand FIFO: loads it once from wide
// memory beats, replays it to a narrow consumer N times, then flushes it.
module rrfifo_replay_ctrl #(
  parameter int unsigned WR_DATA_WIDTH = 64,
  parameter int unsigned RD_DATA_WIDTH = 32,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned MAX_REPLAYS   = 255,
  parameter int unsigned RATIO         = WR_DATA_WIDTH / RD_DATA_WIDTH,
  parameter int unsigned RepW          = $clog2(MAX_REPLAYS + 1),
  parameter int unsigned IdxW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [RepW-1:0]          cmd_replays_i,
  input  logic                     abort_i,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [WR_DATA_WIDTH-1:0] mem_data_i,
  output logic                     fifo_push_o,
  output logic [WR_DATA_WIDTH-1:0] fifo_wdata_o,
  input  logic                     fifo_full_i,
  input  logic                     fifo_load_finished_i,
  output logic                     fifo_pop_o,
  input  logic [RD_DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                     fifo_flush_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [RD_DATA_WIDTH-1:0] out_data_o,
  output logic                     out_last_o,
  output logic                     out_final_o,
  output logic                     busy_o,
  output logic                     done_o
);

  if ((RATIO == 0) || (DEPTH % RATIO != 0)) begin : g_bad_cfg
    $error("DEPTH must be a non-zero multiple of WR_DATA_WIDTH/RD_DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_REPLAY,
    S_FLUSH
  } state_e;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
  localparam logic [RepW-1:0] MaxRep  = RepW'(MAX_REPLAYS);

  state_e          r_state;
  state_e          w_next;
  logic [RepW-1:0] r_passes;
  logic [RepW-1:0] r_pass_cnt;
  logic [IdxW-1:0] r_elem_cnt;
  logic            r_done;
  logic            w_cmd_fire;
  logic [RepW-1:0] w_passes_clamped;

  assign w_cmd_fire       = cmd_valid_i & cmd_ready_o;
  assign w_passes_clamped = (cmd_replays_i > MaxRep) ? MaxRep : cmd_replays_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (cmd_valid_i) w_next = S_LOAD;
      S_LOAD: begin
        if (abort_i) begin
          w_next = S_FLUSH;
        end else if (fifo_load_finished_i && fifo_push_o) begin
          w_next = (r_passes == '0) ? S_FLUSH : S_REPLAY;
        end
      end
      S_REPLAY: if (abort_i || (fifo_pop_o && out_final_o)) w_next = S_FLUSH;
      S_FLUSH:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o  = 1'b0;
    mem_ready_o  = 1'b0;
    out_valid_o  = 1'b0;
    out_last_o   = 1'b0;
    out_final_o  = 1'b0;
    fifo_flush_o = 1'b0;
    unique case (r_state)
      S_IDLE:   cmd_ready_o = 1'b1;
      S_LOAD:   mem_ready_o = ~fifo_full_i & ~abort_i;
      S_REPLAY: begin
        out_valid_o = 1'b1;
        out_last_o  = (r_elem_cnt == LastIdx);
        out_final_o = out_last_o & (r_pass_cnt == r_passes - RepW'(1));
      end
      S_FLUSH:  fifo_flush_o = 1'b1;
      default:  cmd_ready_o = 1'b0;
    endcase
  end

  assign fifo_push_o  = mem_valid_i & mem_ready_o;
  assign fifo_wdata_o = mem_data_i;
  assign fifo_pop_o   = out_valid_o & out_ready_i & ~abort_i;
  assign out_data_o   = fifo_rdata_i;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = r_done;

  // Element index wraps per pass; the pass counter only advances on a wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_passes   <= '0;
      r_pass_cnt <= '0;
      r_elem_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_FLUSH);
      if (w_cmd_fire) begin
        r_passes   <= w_passes_clamped;
        r_pass_cnt <= '0;
        r_elem_cnt <= '0;
      end else if (fifo_pop_o) begin
        if (r_elem_cnt == LastIdx) begin
          r_elem_cnt <= '0;
          r_pass_cnt <= r_pass_cnt + RepW'(1);
        end else begin
          r_elem_cnt <= r_elem_cnt + IdxW'(1);
        end
      end
    end
  end

endmodule

// File: doc/rrfifo_replay_ctrl.md
Name: rrfifo_replay_ctrl

Overview:
- Sequencer that owns one re-readable operand FIFO in the VLSU.
- On a command, it loads the FIFO once from a wide memory-beat stream.
- It then replays the full FIFO contents to a narrow consumer a commanded number of times.
- It then flushes the FIFO and signals completion, so reused operands (e.g. a row broadcast over several vector ops) are fetched from memory only once.

Parameters:
- WR_DATA_WIDTH, 64: memory beat width (FIFO write width).
- RD_DATA_WIDTH, 32: consumer element width (FIFO read width).
- DEPTH, 8: FIFO depth in RD elements. Must be a multiple of RATIO.
- MAX_REPLAYS, 255: largest pass count accepted.
- RATIO (derived), WR_DATA_WIDTH/RD_DATA_WIDTH: elements per beat.
- RepW (derived), $clog2(MAX_REPLAYS+1).
- IdxW (derived), max(1,$clog2(DEPTH)).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  controller idle, command accepted on valid&ready.
- cmd_replays_i  in  RepW  number of full read passes.
- abort_i  in  1  synchronous abort of current command.
- mem_valid_i  in  1  memory beat valid.
- mem_ready_o  out  1  beat accepted on valid&ready.
- mem_data_i  in  WR_DATA_WIDTH  memory beat.
- fifo_push_o  out  1  FIFO push.
- fifo_wdata_o  out  WR_DATA_WIDTH  FIFO write data (= mem_data_i).
- fifo_full_i  in  1  FIFO full flag.
- fifo_load_finished_i  in  1  FIFO pulse on the final load push.
- fifo_pop_o  out  1  FIFO pop.
- fifo_rdata_i  in  RD_DATA_WIDTH  FIFO head data.
- fifo_flush_o  out  1  FIFO flush.
- out_valid_o  out  1  consumer element valid.
- out_ready_i  in  1  consumer accepts.
- out_data_o  out  RD_DATA_WIDTH  element (= fifo_rdata_i).
- out_last_o  out  1  last element of a pass.
- out_final_o  out  1  last element of last pass.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: state IDLE, all counters 0.
  - Outputs at reset: cmd_ready_o=1, all other outputs 0.
  - Reset is honoured mid-operation from any state with no flush pulse. The FIFO shares rst_ni.
- States are IDLE, LOAD, REPLAY, FLUSH. FSM, counters and done_o are registered. Handshake outputs are combinational from state and inputs.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch passes = min(cmd_replays_i, MAX_REPLAYS), clear elem_cnt/pass_cnt, go to LOAD next cycle.
- LOAD:
  - mem_ready_o = ~fifo_full_i & ~abort_i. fifo_push_o = mem_valid_i & mem_ready_o.
  - A load completes in exactly DEPTH/RATIO accepted beats.
  - When fifo_load_finished_i=1 (same cycle as last push): if passes==0 go to FLUSH, else go to REPLAY.
  - No consumer output during LOAD.
- REPLAY:
  - out_valid_o=1. fifo_pop_o = out_ready_i & ~abort_i.
  - out_last_o = (elem_cnt==DEPTH-1).
  - out_final_o = out_last_o & (pass_cnt==passes-1).
  - On each pop, elem_cnt increments and wraps DEPTH-1 → 0. On wrap, pass_cnt increments.
  - A pop with out_final_o set transitions to FLUSH.
  - out_valid_o, out_data_o and flags hold stable while out_ready_i=0.
- FLUSH (exactly one cycle):
  - fifo_flush_o=1, done_o pulses the following cycle, then go to IDLE. cmd_ready_o=0 during FLUSH.
  - A new command is accepted the cycle after FLUSH at earliest.
- abort_i in LOAD or REPLAY:
  - Suppresses the handshake that cycle: mem_ready_o=0 and fifo_pop_o=0, with no beat or element transferred.
  - Next state is FLUSH, with done_o as normal.
  - abort_i is ignored in IDLE and FLUSH.
- Simultaneous events:
  - The last load beat together with abort_i is not accepted; abort wins.
  - cmd_valid_i outside IDLE is ignored (cmd_ready_o=0).
- Arithmetic:
  - elem_cnt is IdxW bits and wraps at DEPTH (non-power-of-two DEPTH uses explicit compare).
  - pass_cnt is RepW bits and never exceeds passes.
- Total elements delivered per command = passes*DEPTH exactly, in FIFO order each pass.

Test Plan:
- Basic replay (DEPTH=8, RATIO=2, replays=3): 4 beats 0x{1,0},{3,2},{5,4},{7,6} with mem_valid held.
  - Expect 4 push cycles, then 24 outputs 0..7 ×3 with out_last at outputs 8/16/24.
  - Expect out_final only at output 24, fifo_flush_o one cycle later, done_o next cycle, cmd_ready_o back to 1.
- Backpressure: out_ready toggles 1/0 each cycle during the same command.
  - Expect 24 transfers over 48 REPLAY cycles with data/flags stable while stalled, and no extra pops.
- Memory stall: mem_valid low for 5 cycles between beats 2 and 3.
  - Expect LOAD to persist, no push while invalid, REPLAY entry the cycle after the 4th beat.
- Zero passes: replays=0.
  - Expect 4 beats loaded, no out_valid_o ever, FLUSH directly after the last beat, done_o asserted.
- Abort: abort_i after 2 beats in LOAD, then a second run aborted mid-pass 2 at element 3.
  - Expect the beat/element on the abort cycle not consumed, one flush cycle, done_o, and a fresh command replaying correctly.
- Reset mid-REPLAY: rst_ni low at element 5 of pass 1.
  - Expect immediate IDLE outputs (cmd_ready_o=1, out_valid_o=0, fifo_flush_o=0), then a normal full command after release.
